// File: rtl/mesh_src_terminal_if.sv
// Terminal-side handshake between a source adapter and one mesh input port.
// The source (master) presents a pending flag and head word; the mesh (slave)
// answers with a pop strobe when it consumes the word.
interface mesh_src_terminal_if #(
    parameter int PAKG_SIZE = 32
);
    logic                 pndng_o;
    logic [PAKG_SIZE-1:0] data_out_o;
    logic                 popin_i;

    modport master (
        output pndng_o,
        output data_out_o,
        input  popin_i
    );

    modport slave (
        input  pndng_o,
        input  data_out_o,
        output popin_i
    );
endinterface

// File: rtl/mesh_src_terminal.sv
// Source terminal adapter for one external mesh port.
// Validates host requests against the set of edge-terminal addresses, formats
// legal ones into mesh packet words and queues them in a first-word-fall-through
// FIFO whose head is offered to the mesh through the pending/data/pop handshake.
module mesh_src_terminal #(
    parameter int ROWS       = 4,
    parameter int COLUMNS    = 4,
    parameter int PAKG_SIZE  = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int MY_ROW     = 0,
    parameter int MY_COL     = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              wr_i,
    input  logic [3:0]                        trgt_row_i,
    input  logic [3:0]                        trgt_col_i,
    input  logic                              mode_i,
    input  logic [PAKG_SIZE-18:0]             payload_i,
    output logic                              full_o,
    output logic [1:0]                        err_o,
    output logic [15:0]                       drop_cnt_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o,
    mesh_src_terminal_if.master               term
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [AW-1:0] LAST_PTR_C = AW'(FIFO_DEPTH - 1);
    localparam logic [3:0]    ROW_MAX_C  = 4'(ROWS);
    localparam logic [3:0]    COL_MAX_C  = 4'(COLUMNS);
    localparam logic [3:0]    ROW_FAR_C  = 4'(ROWS + 1);
    localparam logic [3:0]    COL_FAR_C  = 4'(COLUMNS + 1);
    localparam logic [3:0]    MY_ROW_C   = 4'(MY_ROW);
    localparam logic [3:0]    MY_COL_C   = 4'(MY_COL);

    localparam logic [1:0] ERR_NONE_C = 2'b00;
    localparam logic [1:0] ERR_OVF_C  = 2'b01;
    localparam logic [1:0] ERR_ADDR_C = 2'b10;

    // A destination is legal only if it names an edge terminal (never a corner)
    // other than this terminal itself.
    function automatic logic addr_legal(input logic [3:0] row, input logic [3:0] col);
        logic row_edge;
        logic col_edge;
        logic row_in;
        logic col_in;
        logic is_self;
        row_edge = (row == 4'd0) || (row == ROW_FAR_C);
        col_edge = (col == 4'd0) || (col == COL_FAR_C);
        row_in   = (row >= 4'd1) && (row <= ROW_MAX_C);
        col_in   = (col >= 4'd1) && (col <= COL_MAX_C);
        is_self  = (row == MY_ROW_C) && (col == MY_COL_C);
        return ((row_edge && col_in) ^ (col_edge && row_in)) && !is_self;
    endfunction

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        logic [AW-1:0] nxt;
        if (ptr == LAST_PTR_C) begin
            nxt = {AW{1'b0}};
        end else begin
            nxt = ptr + AW'(1);
        end
        return nxt;
    endfunction

    logic [PAKG_SIZE-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [CW-1:0]        count_r;
    logic                 pndng_r;
    logic                 full_r;
    logic [1:0]           err_r;
    logic [15:0]          drop_cnt_r;

    logic                 pop_s;
    logic                 push_s;
    logic                 bad_addr_s;
    logic                 ovf_s;
    logic [PAKG_SIZE-1:0] word_s;
    logic [CW-1:0]        count_nxt_s;
    logic [AW-1:0]        wr_ptr_nxt_s;
    logic [AW-1:0]        rd_ptr_nxt_s;
    logic [1:0]           err_nxt_s;
    logic [15:0]          drop_cnt_nxt_s;

    // Classify the current request/pop and compute every next-state value.
    always_comb begin
        pop_s          = term.popin_i && pndng_r;
        bad_addr_s     = wr_i && !addr_legal(trgt_row_i, trgt_col_i);
        push_s         = wr_i && !bad_addr_s && (!full_r || pop_s);
        ovf_s          = wr_i && !bad_addr_s && full_r && !pop_s;
        word_s         = {8'h00, trgt_row_i, trgt_col_i, mode_i, payload_i};
        count_nxt_s    = count_r;
        wr_ptr_nxt_s   = wr_ptr_r;
        rd_ptr_nxt_s   = rd_ptr_r;
        err_nxt_s      = ERR_NONE_C;
        drop_cnt_nxt_s = drop_cnt_r;

        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase

        if (push_s) begin
            wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (pop_s) begin
            rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        // A bad address outranks overflow when both could apply.
        if (bad_addr_s) begin
            err_nxt_s = ERR_ADDR_C;
        end else if (ovf_s) begin
            err_nxt_s = ERR_OVF_C;
        end else begin
            err_nxt_s = ERR_NONE_C;
        end

        if ((bad_addr_s || ovf_s) && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_nxt_s = drop_cnt_r + 16'd1;
        end else begin
            drop_cnt_nxt_s = drop_cnt_r;
        end
    end

    // Control state: pointers, occupancy, status flags and error reporting.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            pndng_r    <= 1'b0;
            full_r     <= 1'b0;
            err_r      <= ERR_NONE_C;
            drop_cnt_r <= 16'd0;
        end else begin
            wr_ptr_r   <= wr_ptr_nxt_s;
            rd_ptr_r   <= rd_ptr_nxt_s;
            count_r    <= count_nxt_s;
            pndng_r    <= (count_nxt_s != {CW{1'b0}});
            full_r     <= (count_nxt_s == DEPTH_C);
            err_r      <= err_nxt_s;
            drop_cnt_r <= drop_cnt_nxt_s;
        end
    end

    // Packet storage; contents are only visible while the FIFO is non-empty,
    // so the array itself needs no reset.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= word_s;
        end
    end

    assign full_o          = full_r;
    assign err_o           = err_r;
    assign drop_cnt_o      = drop_cnt_r;
    assign count_o         = count_r;
    assign term.pndng_o    = pndng_r;
    assign term.data_out_o = pndng_r ? mem_r[rd_ptr_r] : {PAKG_SIZE{1'b0}};

endmodule

// File: doc/mesh_src_terminal.md
Name: mesh_src_terminal

Overview:
- Source terminal adapter that sits directly upstream of one external port of the mesh router array.
- Accepts packet requests from a host or agent side (target row/column, routing mode, payload) and checks that the destination address is legal.
- Formats each legal request into the mesh packet word and buffers it in a FIFO.
- Presents the FIFO head to the mesh through the pending/data/pop handshake that the mesh uses on its terminal inputs.

Parameters:
- ROWS, 4, mesh row count.
- COLUMNS, 4, mesh column count.
- PAKG_SIZE, 32, packet width in bits; must be >= 24.
- FIFO_DEPTH, 16, buffer entries; must be >= 2.
- MY_ROW, 0, this terminal's row address.
- MY_COL, 1, this terminal's column address.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- wr_i  in  1  host write strobe, one request per cycle.
- trgt_row_i  in  4  destination row.
- trgt_col_i  in  4  destination column.
- mode_i  in  1  routing mode (1 = row-first, 0 = column-first).
- payload_i  in  PAKG_SIZE-17  packet payload.
- full_o  out  1  FIFO holds FIFO_DEPTH entries.
- err_o  out  2  one-cycle error code: 00 none, 01 overflow drop, 10 bad address.
- drop_cnt_o  out  16  count of rejected writes; saturates at 16'hFFFF.
- count_o  out  $clog2(FIFO_DEPTH+1)  current occupancy.
- pndng_o  out  1  to mesh pndng_i_in; FIFO not empty.
- data_out_o  out  PAKG_SIZE  to mesh data_out_i_in; FIFO head word.
- popin_i  in  1  from mesh popin; consume the head word.

Behaviour:
- Packet format:
  - [PAKG_SIZE-1 : PAKG_SIZE-8] = 8'h00 (next-jump field, cleared at injection).
  - [PAKG_SIZE-9 : PAKG_SIZE-12] = trgt_row_i.
  - [PAKG_SIZE-13 : PAKG_SIZE-16] = trgt_col_i.
  - [PAKG_SIZE-17] = mode_i.
  - [PAKG_SIZE-18 : 0] = payload_i.
  - The word is formed combinationally and stored on the accepting edge.
- Address legality: a destination is legal only if it is an edge terminal, i.e. exactly one of:
  - row in {0, ROWS+1} with col in 1..COLUMNS, or
  - col in {0, COLUMNS+1} with row in 1..ROWS.
  - A destination equal to (MY_ROW, MY_COL) is illegal.
  - Corner addresses, e.g. (0,0), are illegal.
- Write with wr_i=1 and an illegal address:
  - Not stored.
  - err_o=10 on the next cycle for exactly one cycle.
  - drop_cnt_o increments by 1.
- Write with wr_i=1, legal address, not full: stored at the tail on that edge; count_o increments by 1.
- Write with wr_i=1, legal address, full, and no pop in the same cycle:
  - Not stored.
  - err_o=01 for one cycle.
  - drop_cnt_o increments by 1.
- Write with wr_i=1, legal address, full, and a valid pop in the same cycle: accepted; count_o is unchanged.
- First-word-fall-through head:
  - pndng_o = (count_o != 0), and data_out_o = head word, both driven from registers/array with no added latency.
  - A word written into an empty FIFO at edge N appears with pndng_o=1 after edge N.
- Pop: popin_i=1 with pndng_o=1 removes the head at the edge; the next word (or an empty FIFO) is visible after that edge.
- popin_i=1 with pndng_o=0: ignored; no underflow, no error, pointers unchanged.
- Simultaneous pop and write while not full: both take effect; count_o is unchanged.
- Simultaneous pop and write while count_o=1: the new word becomes the head and pndng_o stays 1.
- Pointers: read and write pointers wrap modulo FIFO_DEPTH. Occupancy is tracked by an explicit counter, not by pointer comparison.
- data_out_o when empty is 0.
- full_o = (count_o == FIFO_DEPTH).
- Reset (rst_i=0, at any time including mid-transfer), asynchronously:
  - Pointers and count cleared; pndng_o=0; full_o=0; data_out_o=0; err_o=00; drop_cnt_o=0.
  - Buffered packets are discarded.
- Release of rst_i is sampled synchronously; the first write is accepted on the first edge with rst_i=1.
- err_o: when both error conditions could apply to the same write, bad address (10) has priority.
- drop_cnt_o holds at 16'hFFFF once saturated; err_o still pulses.

Test Plan:
- Reset, then write row=0, col=2, mode=1, payload=15'h1234 with PAKG_SIZE=32 -> next cycle pndng_o=1, data_out_o=32'h0002_9234, count_o=1.
- Fill 16 legal writes with popin_i=0 -> full_o=1; 17th write gives err_o=01 for one cycle, drop_cnt_o=1, count_o stays 16.
- With full_o=1, assert wr_i and popin_i together -> count_o=16, the first stored word is removed, the new word is at the tail; pop all 16 and confirm FIFO order with wrap-around.
- Write illegal destinations (0,0), (5,5), (MY_ROW,MY_COL) -> no storage, err_o=10 each time, drop_cnt_o=3.
- popin_i=1 on empty for 5 cycles -> pndng_o=0, count_o=0, err_o=00; then one write is followed by a single correct pop.
- Load 5 words, assert rst_i=0 mid-cycle -> outputs clear immediately without a clock edge; after release, first write is the new head and count_o=1.
